// File: rtl/aes_lite_pkg.sv
// Shared constants and types for the AES-lite output serializer.
// Holds the default cipher byte width and the serializer state encoding.
// Imported by the serializer top and its FIFO.
package aes_lite_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } ser_state_e;

endpackage

// File: rtl/aes_lite_sync_fifo.sv
// Purpose: synchronous FIFO holding captured cipher bytes ahead of the serializer.
// Latency: a written byte is visible at rd_data the cycle after the write edge.
// Backpressure: writes while full are refused unless a read happens the same cycle.
module aes_lite_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  import aes_lite_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A simultaneous read frees a slot, so a write into a full FIFO is still accepted.
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_lite_out_serializer.sv
// Purpose: capture AES-lite result bytes on ready_in rising edges and emit them MSB first.
// Latency: push at edge N into an idle, empty path gives the first valid bit after edge N+1.
// Backpressure: tx_ready low stalls the shifter; a push into a full FIFO with no pop is dropped.
module aes_lite_out_serializer #(
  parameter int DATA_W = aes_lite_pkg::DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       ready_in,
  input  logic                       tx_ready,
  input  logic                       clear_ovf,
  output logic                       ser_out,
  output logic                       ser_valid,
  output logic                       frame_start,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);
  import aes_lite_pkg::*;

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic              ready_q;
  logic              push;
  logic              pop;
  logic              shift;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  ser_state_e        state;
  ser_state_e        state_nxt;

  // Edge detector on ready_in; resets high so a level already present at release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b1;
    else     ready_q <= ready_in;
  end

  assign push = ready_in && !ready_q;

  // Sticky overflow: a dropped byte sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              overflow <= 1'b0;
    else if (push && fifo_full && !pop)   overflow <= 1'b1;
    else if (clear_ovf)                   overflow <= 1'b0;
  end

  aes_lite_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Serializer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode; outputs are forced low outside S_SHIFT.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    shift       = 1'b0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    case (state)
      S_IDLE: begin
        // Loading does not wait for tx_ready so the byte is staged ahead of the sink.
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ser_out     = shreg[DATA_W-1];
        ser_valid   = tx_ready;
        frame_start = tx_ready && (bitcnt == '0);
        if (tx_ready) begin
          shift = 1'b1;
          if (bitcnt == LAST_BIT) state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Shift register and bit counter: load on pop, advance only on an accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (pop) begin
      shreg  <= head;
      bitcnt <= '0;
    end else if (shift) begin
      shreg  <= shreg << 1;
      bitcnt <= bitcnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_aes_lite_out_serializer.sv
// Self-checking bench for aes_lite_out_serializer: directed scenarios plus random bursts.
// Expected serial stream comes from a queue of bits built from each accepted byte, MSB first.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_aes_lite_out_serializer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          ready_in;
  logic          tx_ready;
  logic          clear_ovf;
  logic          ser_out;
  logic          ser_valid;
  logic          frame_start;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int obs_base = 0;
  bit rand_tx = 1'b0;

  bit obs_bits[$];
  bit obs_fs[$];
  int obs_cyc[$];
  bit exp_bits[$];

  always #5 clk = ~clk;

  aes_lite_out_serializer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .ready_in    (ready_in),
    .tx_ready    (tx_ready),
    .clear_ovf   (clear_ovf),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Record every valid serial bit with its frame marker and cycle number.
  always @(negedge clk) begin
    if (rst === 1'b0 && ser_valid === 1'b1) begin
      obs_bits.push_back(ser_out);
      obs_fs.push_back(frame_start);
      obs_cyc.push_back(cyc_cnt);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_tx) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic model_push(input logic [DW-1:0] b);
    for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic push_raw(input logic [DW-1:0] b);
    cyc();
    data_in  = b;
    ready_in = 1'b1;
    cyc();
    ready_in = 1'b0;
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    push_raw(b);
    model_push(b);
  endtask

  task automatic wait_bits(input int n);
    int waited;
    waited = 0;
    while ((obs_bits.size() < obs_base + n) && (waited < 200)) begin
      cyc();
      waited++;
    end
    check("wait_bits", 32'(obs_bits.size() >= obs_base + n), 32'd1);
  endtask

  // Compare everything the model expects against the observed stream.
  task automatic drain(input string tag);
    int n;
    int waited;
    n = exp_bits.size();
    waited = 0;
    while ((obs_bits.size() < obs_base + n) && (waited < 40 * n + 60)) begin
      cyc();
      waited++;
    end
    check($sformatf("%s_complete", tag), 32'(obs_bits.size() >= obs_base + n), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (obs_base + i < obs_bits.size()) begin
        check($sformatf("%s_bit%0d", tag, i), 32'(obs_bits[obs_base + i]), 32'(exp_bits[i]));
        check($sformatf("%s_fs%0d", tag, i), 32'(obs_fs[obs_base + i]), 32'(i % DW == 0));
        if ((i % DW == 0) && (i >= DW))
          check($sformatf("%s_spacing%0d", tag, i),
                32'(obs_cyc[obs_base + i] - obs_cyc[obs_base + i - DW] >= DW + 2), 32'd1);
      end
    end
    obs_base = obs_bits.size();
    exp_bits.delete();
    cyc();
    check($sformatf("%s_count_empty", tag), 32'(fifo_count), 32'd0);
    check($sformatf("%s_no_ovf", tag), 32'(overflow), 32'd0);
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    ready_in  = 1'b0;
    tx_ready  = 1'b0;
    clear_ovf = 1'b0;
    data_in   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst      = 1'b0;
    tx_ready = 1'b1;

    // Single byte 0xA5 with latency check
    cyc();
    data_in  = 8'hA5;
    ready_in = 1'b1;
    cyc();
    ready_in = 1'b0;
    model_push(8'hA5);
    wait_neg();
    check("lat_count_after_push", 32'(fifo_count), 32'd1);
    check("lat_not_yet_valid", 32'(ser_valid), 32'd0);
    wait_neg();
    check("lat_first_valid", 32'(ser_valid), 32'd1);
    check("lat_first_fs", 32'(frame_start), 32'd1);
    check("lat_first_bit", 32'(ser_out), 32'd1);
    drain("a5");

    // Backpressure on 0x3C: stall three cycles after three bits
    push_byte(8'h3C);
    wait_bits(3);
    tx_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wait_neg();
      check($sformatf("stall%0d_valid", s), 32'(ser_valid), 32'd0);
      check($sformatf("stall%0d_hold", s), 32'(ser_out), 32'(exp_bits[3]));
      check($sformatf("stall%0d_fs", s), 32'(frame_start), 32'd0);
      cyc();
    end
    tx_ready = 1'b1;
    drain("bp3c");

    // Overflow: six pushes with the sink blocked
    cyc();
    tx_ready = 1'b0;
    for (int b = 1; b <= 5; b++) push_byte(8'(b));
    push_raw(8'h06);
    wait_neg();
    check("ovf_count_full", 32'(fifo_count), 32'd4);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_no_valid", 32'(ser_valid), 32'd0);
    check("ovf_ser_out_low", 32'(ser_out), 32'd0);
    cyc();
    clear_ovf = 1'b1;
    cyc();
    clear_ovf = 1'b0;
    wait_neg();
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_count_kept", 32'(fifo_count), 32'd4);
    // Release the sink and land a push on the edge where the FSM pops a full FIFO
    cyc();
    tx_ready = 1'b1;
    repeat (DW + 1) @(posedge clk);
    #1;
    data_in  = 8'h77;
    ready_in = 1'b1;
    cyc();
    ready_in = 1'b0;
    wait_neg();
    check("full_pushpop_count", 32'(fifo_count), 32'd4);
    check("full_pushpop_no_ovf", 32'(overflow), 32'd0);
    model_push(8'h77);
    drain("ovf");

    // Level hold: ready_in high for five cycles gives one byte
    cyc();
    data_in  = 8'h5A;
    ready_in = 1'b1;
    repeat (4) cyc();
    ready_in = 1'b0;
    model_push(8'h5A);
    drain("hold");
    repeat (15) cyc();
    check("hold_no_extra", 32'(obs_bits.size() - obs_base), 32'd0);

    // ready_in high across reset release: no capture
    cyc();
    data_in  = 8'h99;
    ready_in = 1'b1;
    rst      = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    ready_in = 1'b0;
    repeat (20) cyc();
    check("rstlvl_no_bits", 32'(obs_bits.size() - obs_base), 32'd0);
    check("rstlvl_count", 32'(fifo_count), 32'd0);

    // Reset mid-shift of 0xFF with another byte queued
    push_byte(8'hFF);
    push_raw(8'h81);
    wait_bits(4);
    check("midrst_queued", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ser_valid", 32'(ser_valid), 32'd0);
    check("midrst_ser_out", 32'(ser_out), 32'd0);
    check("midrst_frame_start", 32'(frame_start), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (obs_base + i < obs_bits.size())
        check($sformatf("midrst_bit%0d", i), 32'(obs_bits[obs_base + i]), 32'(exp_bits[i]));
    end
    cyc();
    cyc();
    rst = 1'b0;
    repeat (25) cyc();
    check("midrst_silent", 32'(obs_bits.size() - obs_base), 32'd4);
    obs_base = obs_bits.size();
    exp_bits.delete();

    // Random bursts with a randomly throttled sink
    rand_tx = 1'b1;
    for (int burst = 0; burst < 8; burst++) begin
      k = int'($urandom_range(1, DEPTH));
      for (int j = 0; j < k; j++) begin
        push_byte(8'($urandom));
        repeat ($urandom_range(0, 2)) cyc();
      end
      drain($sformatf("rnd%0d", burst));
    end
    rand_tx  = 1'b0;
    tx_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_lite_out_serializer.md
AES_LITE_OUT_SERIALIZER -- requirements
Module: aes_lite_out_serializer

Interface
REQ-001 Parameter DATA_W, default 8: width of each captured cipher byte and of the shift register.
REQ-002 Parameter DEPTH, default 4: number of FIFO entries; power of two, at least 2.
REQ-003 Port clk, input, 1 bit: the block's only clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port data_in, input, DATA_W bits: encrypted byte driven by the upstream AES-lite core.
REQ-006 Port ready_in, input, 1 bit: upstream "result valid" flag; its rising edge marks a new byte.
REQ-007 Port tx_ready, input, 1 bit: downstream permits a bit transfer in this cycle.
REQ-008 Port clear_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-009 Port ser_out, output, 1 bit: serial data, MSB first.
REQ-010 Port ser_valid, output, 1 bit: ser_out carries a valid bit in this cycle.
REQ-011 Port frame_start, output, 1 bit: high only in the cycle that carries bit DATA_W-1 of a byte.
REQ-012 Port fifo_count, output, clog2(DEPTH+1) bits: FIFO occupancy, range 0 to DEPTH.
REQ-013 Port overflow, output, 1 bit: sticky; a byte was dropped because the FIFO was full.

Function
REQ-014 Capture: register ready_in into ready_q; a push occurs at a clock edge where ready_in=1 and ready_q=0; data_in is stored at that same edge.
REQ-015 ready_in held high for multiple cycles produces exactly one push.
REQ-016 Push with count<DEPTH: write the byte and increment count.
REQ-017 Push with count=DEPTH and no pop in the same cycle: drop the byte and set overflow.
REQ-018 Push and pop in the same cycle: accept both and leave count unchanged, including when count=DEPTH.
REQ-019 Read and write pointers wrap modulo DEPTH; FIFO order is strictly first-in, first-out.
REQ-020 overflow: clear_ovf=1 clears it at the next edge; when set and clear occur in the same cycle, set wins.
REQ-021 Serializer FSM states: S_IDLE, S_SHIFT, S_GAP.
REQ-022 S_IDLE: when count>0, pop the head entry into the shift register, clear the bit counter, and go to S_SHIFT; tx_ready is not required to pop.
REQ-023 S_SHIFT: ser_out = shift register MSB, combinationally.
REQ-024 S_SHIFT: ser_valid = tx_ready.
REQ-025 S_SHIFT with tx_ready=1: shift left by 1 and increment the bit counter at the edge.
REQ-026 S_SHIFT with tx_ready=0: stall; shift register and bit counter hold.
REQ-027 S_SHIFT: after the transfer with bit counter = DATA_W-1, go to S_GAP.
REQ-028 S_GAP: ser_valid=0 for exactly one cycle, then go to S_IDLE.
REQ-029 Minimum byte spacing on the serial side: DATA_W+2 cycles.
REQ-030 frame_start = ser_valid AND bit counter = 0.
REQ-031 Outside S_SHIFT: ser_out=0, ser_valid=0, frame_start=0.
REQ-032 Latency: for a push at edge N into an empty FIFO with the FSM in S_IDLE and tx_ready=1, the first bit is valid in the cycle after edge N+1.

Reset
REQ-033 rst=1 immediately forces: FSM=S_IDLE, FIFO empty, pointers=0, fifo_count=0, overflow=0, ser_out=0, ser_valid=0, frame_start=0, shift register=0, bit counter=0.
REQ-034 ready_q resets to 1, so ready_in already high at reset release does not cause a capture.
REQ-035 Reset asserted mid-byte abandons the byte and all queued bytes; nothing is emitted after reset release until a new push.

Structure
REQ-036 Shared package aes_lite_pkg holds DATA_W and the serializer state enum.
REQ-037 Sub-module aes_lite_sync_fifo holds storage, pointers, count, and full/empty; the top holds capture, overflow, and the FSM.

Verification
REQ-038 Single byte: ready_in pulse with data_in=0xA5, tx_ready=1 -> serial sequence 1,0,1,0,0,1,0,1; frame_start on the first bit; fifo_count returns to 0.
REQ-039 Backpressure: byte 0x3C, tx_ready low for 3 cycles after bit 2 -> the same bit is held, ser_valid=0 during the stall, correct 8-bit sequence overall.
REQ-040 Overflow: 6 pushes (0x01 to 0x06) with tx_ready=0 -> 0x01 in the shift register, 0x02 to 0x05 queued, 0x06 dropped, overflow=1; clear_ovf clears it.
REQ-041 Level hold and reset: ready_in held high for 5 cycles -> one push; ready_in high during and after reset release -> no push.
REQ-042 Reset mid-shift: rst asserted at bit 4 of 0xFF -> outputs 0 immediately; no bits emitted after release.
